// File: rtl/adding_machine_controller.sv
`default_nettype none
// ============================================================================
// Module      : adding_machine_controller
// Description : Control sequencer for a small accumulator machine with the
//               instruction set LDA / STA / ADD / JMP. The sequence for each
//               instruction is FETCH, DECODE, then one execute state. Memory
//               accesses stall on mem_rdy and fall into a sticky ERROR state
//               when TIMEOUT stall cycles pass without a handshake.
// Ports       : clk, reset       - clock, asynchronous active-high reset
//               op_code[1:0]     - IR opcode (00 LDA, 01 STA, 10 ADD, 11 JMP)
//               mem_rdy          - completion strobe for rd_mem / wr_mem
//               halt             - stop request, sampled between instructions
//               ir_on_adr .. select, rd_mem, wr_mem - datapath/memory controls
//               err              - sticky memory-timeout flag
//               busy             - high except in IDLE and ERROR
//               instr_cnt[7:0]   - retired-instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module adding_machine_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op_code,
    input  logic       mem_rdy,
    input  logic       halt,
    output logic       ir_on_adr,
    output logic       pc_on_adr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       clr_pc,
    output logic       pass_add,
    output logic       select,
    output logic       rd_mem,
    output logic       wr_mem,
    output logic       err,
    output logic       busy,
    output logic [7:0] instr_cnt
);

    localparam logic [3:0] C_ST_CLR    = 4'd0;
    localparam logic [3:0] C_ST_IDLE   = 4'd1;
    localparam logic [3:0] C_ST_FETCH  = 4'd2;
    localparam logic [3:0] C_ST_DECODE = 4'd3;
    localparam logic [3:0] C_ST_LDA    = 4'd4;
    localparam logic [3:0] C_ST_STA    = 4'd5;
    localparam logic [3:0] C_ST_ADD    = 4'd6;
    localparam logic [3:0] C_ST_JMP    = 4'd7;
    localparam logic [3:0] C_ST_ERROR  = 4'd8;

    // Last wait-counter value that may still stall; one more stall times out.
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] cnt_q, cnt_d;

    logic w_mem_state;
    logic w_stall;
    logic w_timeout;
    logic w_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_ST_CLR;
            wait_q  <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_state = (state_q == C_ST_FETCH) || (state_q == C_ST_LDA) ||
                      (state_q == C_ST_STA);
        w_stall     = w_mem_state && !mem_rdy;
        w_timeout   = w_stall && (wait_q == C_WAIT_LAST);
        w_done      = (((state_q == C_ST_LDA) || (state_q == C_ST_STA)) && mem_rdy) ||
                      (state_q == C_ST_ADD) || (state_q == C_ST_JMP);

        // Any non-stall cycle clears the counter, so it is always zero on
        // entry to a memory-wait state (those are never entered from
        // themselves).
        wait_d = w_stall ? (wait_q + 8'd1) : 8'd0;
        cnt_d  = w_done  ? (cnt_q + 8'd1)  : cnt_q;

        state_d = state_q;
        case (state_q)
            C_ST_CLR,
            C_ST_IDLE:   state_d = halt ? C_ST_IDLE : C_ST_FETCH;
            C_ST_FETCH: begin
                if (mem_rdy)        state_d = C_ST_DECODE;
                else if (w_timeout) state_d = C_ST_ERROR;
            end
            C_ST_DECODE: begin
                case (op_code)
                    2'b00:   state_d = C_ST_LDA;
                    2'b01:   state_d = C_ST_STA;
                    2'b10:   state_d = C_ST_ADD;
                    default: state_d = C_ST_JMP;
                endcase
            end
            C_ST_LDA,
            C_ST_STA: begin
                // mem_rdy wins over a timeout in the same cycle.
                if (mem_rdy)        state_d = halt ? C_ST_IDLE : C_ST_FETCH;
                else if (w_timeout) state_d = C_ST_ERROR;
            end
            C_ST_ADD,
            C_ST_JMP:    state_d = halt ? C_ST_IDLE : C_ST_FETCH;
            C_ST_ERROR:  state_d = C_ST_ERROR;
            default:     state_d = C_ST_ERROR;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        ir_on_adr = 1'b0;
        pc_on_adr = 1'b0;
        ld_ir     = 1'b0;
        ld_ac     = 1'b0;
        ld_pc     = 1'b0;
        inc_pc    = 1'b0;
        clr_pc    = 1'b0;
        pass_add  = 1'b0;
        select    = 1'b0;
        rd_mem    = 1'b0;
        wr_mem    = 1'b0;
        err       = 1'b0;
        busy      = 1'b1;
        case (state_q)
            C_ST_CLR:    clr_pc = 1'b1;
            C_ST_IDLE:   busy   = 1'b0;
            C_ST_FETCH: begin
                pc_on_adr = 1'b1;
                rd_mem    = 1'b1;
                ld_ir     = mem_rdy;
            end
            C_ST_DECODE: inc_pc = 1'b1;
            C_ST_LDA: begin
                ir_on_adr = 1'b1;
                rd_mem    = 1'b1;
                ld_ac     = mem_rdy;
            end
            C_ST_STA: begin
                ir_on_adr = 1'b1;
                wr_mem    = 1'b1;
            end
            C_ST_ADD: begin
                pass_add = 1'b1;
                select   = 1'b1;
                ld_ac    = 1'b1;
            end
            C_ST_JMP:    ld_pc  = 1'b1;
            default: begin
                err  = 1'b1;
                busy = 1'b0;
            end
        endcase
    end

    assign instr_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adding_machine_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_adding_machine_controller
// Description : Self-checking bench for adding_machine_controller. Directed
//               scenarios followed by randomized traffic, every cycle compared
//               against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adding_machine_controller;

    localparam int TB_TIMEOUT = 15;

    // Model phases: the execute step of every opcode is a single phase.
    localparam int P_CLR    = 0;
    localparam int P_IDLE   = 1;
    localparam int P_FETCH  = 2;
    localparam int P_DECODE = 3;
    localparam int P_EXEC   = 4;
    localparam int P_ERROR  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op_code;
    logic       mem_rdy;
    logic       halt;
    logic       ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc;
    logic       pass_add, select, rd_mem, wr_mem, err, busy;
    logic [7:0] instr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase = P_CLR;
    int m_op    = 0;
    int m_stall = 0;
    int m_cnt   = 0;

    adding_machine_controller #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_code   (op_code),
        .mem_rdy   (mem_rdy),
        .halt      (halt),
        .ir_on_adr (ir_on_adr),
        .pc_on_adr (pc_on_adr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .clr_pc    (clr_pc),
        .pass_add  (pass_add),
        .select    (select),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .err       (err),
        .busy      (busy),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Control vector order:
    // {ir_on_adr,pc_on_adr,ld_ir,ld_ac,ld_pc,inc_pc,clr_pc,pass_add,select,rd_mem,wr_mem,err,busy}
    function automatic logic [12:0] exp_ctrl(input int ph, input int op, input logic rdy);
        logic a_ir = 0, a_pc = 0, l_ir = 0, l_ac = 0, l_pc = 0, i_pc = 0, c_pc = 0;
        logic p_add = 0, sel = 0, rd = 0, wr = 0, e = 0, b = 1;
        case (ph)
            P_CLR:    c_pc = 1;
            P_IDLE:   b = 0;
            P_FETCH:  begin a_pc = 1; rd = 1; l_ir = rdy; end
            P_DECODE: i_pc = 1;
            P_EXEC: begin
                case (op)
                    0:       begin a_ir = 1; rd = 1; l_ac = rdy; end
                    1:       begin a_ir = 1; wr = 1; end
                    2:       begin p_add = 1; sel = 1; l_ac = 1; end
                    default: l_pc = 1;
                endcase
            end
            default:  begin e = 1; b = 0; end
        endcase
        return {a_ir, a_pc, l_ir, l_ac, l_pc, i_pc, c_pc, p_add, sel, rd, wr, e, b};
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_advance();
        if (reset) begin
            m_phase = P_CLR;
            m_stall = 0;
            m_cnt   = 0;
        end else begin
            case (m_phase)
                P_CLR, P_IDLE: begin
                    m_stall = 0;
                    m_phase = halt ? P_IDLE : P_FETCH;
                end
                P_FETCH: begin
                    if (mem_rdy) begin
                        m_phase = P_DECODE;
                        m_stall = 0;
                    end else begin
                        m_stall++;
                        if (m_stall == TB_TIMEOUT) m_phase = P_ERROR;
                    end
                end
                P_DECODE: begin
                    m_op    = int'(op_code);
                    m_phase = P_EXEC;
                    m_stall = 0;
                end
                P_EXEC: begin
                    if (m_op >= 2 || mem_rdy) begin
                        m_cnt   = (m_cnt + 1) % 256;
                        m_stall = 0;
                        m_phase = halt ? P_IDLE : P_FETCH;
                    end else begin
                        m_stall++;
                        if (m_stall == TB_TIMEOUT) m_phase = P_ERROR;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Apply inputs just after a rising edge, check mid-cycle, then advance.
    task automatic step(input logic rst_v, input logic halt_v, input logic rdy_v,
                        input logic [1:0] op_v);
        reset   = rst_v;
        halt    = halt_v;
        mem_rdy = rdy_v;
        op_code = op_v;
        if (rst_v) begin
            m_phase = P_CLR;
            m_stall = 0;
            m_cnt   = 0;
        end
        @(negedge clk);
        check_val("ctrl", 32'({ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc,
                               pass_add, select, rd_mem, wr_mem, err, busy}),
                  32'(exp_ctrl(m_phase, m_op, mem_rdy)));
        check_val("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        halt    = 1'b0;
        mem_rdy = 1'b0;
        op_code = 2'b00;
        @(posedge clk);
        #1;

        // Reset held: CLR with clr_pc and busy.
        step(1, 0, 1, 2'b10);
        step(1, 0, 1, 2'b10);

        // ADD with zero wait: CLR, FETCH, DECODE, ADD, then count = 1.
        repeat (4) step(0, 0, 1, 2'b10);

        // LDA with three wait cycles in the execute state.
        step(0, 0, 1, 2'b00);
        step(0, 0, 1, 2'b00);
        repeat (3) step(0, 0, 0, 2'b00);
        step(0, 0, 1, 2'b00);

        // FETCH timeout after 15 stalls; ERROR is sticky.
        repeat (15) step(0, 0, 0, 2'b00);
        repeat (3) step(0, 0, 1, 2'b00);
        step(1, 0, 0, 2'b00);

        // 14 stalls then mem_rdy on the 15th stall cycle: no error.
        step(0, 0, 1, 2'b10);
        repeat (14) step(0, 0, 0, 2'b10);
        step(0, 0, 1, 2'b10);
        step(0, 0, 1, 2'b10);
        step(0, 0, 1, 2'b10);

        // JMP with halt raised during DECODE: completes, then IDLE, then FETCH.
        step(0, 0, 1, 2'b11);
        step(0, 1, 1, 2'b11);
        step(0, 1, 1, 2'b11);
        step(0, 1, 1, 2'b11);
        step(0, 0, 1, 2'b11);

        // 256 ADD instructions wrap the counter.
        repeat (256 * 3) step(0, 0, 1, 2'b10);

        // STA interrupted by reset while waiting on memory.
        step(0, 0, 1, 2'b01);
        step(0, 0, 1, 2'b01);
        step(0, 0, 0, 2'b01);
        step(1, 0, 0, 2'b01);
        step(0, 0, 1, 2'b01);

        // Randomized traffic with varying memory responsiveness.
        for (int seg = 0; seg < 40; seg++) begin
            int p_rdy;
            p_rdy = (seg % 3 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(40, 100));
            for (int c = 0; c < 80; c++) begin
                logic r_v, h_v, m_v;
                logic [1:0] o_v;
                r_v = ($urandom_range(0, 99) < 2);
                h_v = ($urandom_range(0, 99) < 10);
                m_v = (int'($urandom_range(0, 99)) < p_rdy);
                o_v = 2'($urandom_range(0, 3));
                step(r_v, h_v, m_v, o_v);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
